// File: rtl/nf10_router_input_arbiter.sv
// Four-input AXI4-Stream merger for the router datapath. Each input lands in a
// small fallthrough FIFO; a round-robin arbiter grants one input at a time and
// holds that grant until the packet's TLAST beat has been handed downstream.
// TDATA/TSTRB/TUSER pass through untouched.
//
// The slave and master widths must be equal. The slave widths size the FIFOs.
module nf10_router_input_arbiter #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned FIFO_DEPTH_BITS      = 2
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_RESETN,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S0_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S0_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S0_AXIS_TUSER,
  input  logic                                S0_AXIS_TVALID,
  output logic                                S0_AXIS_TREADY,
  input  logic                                S0_AXIS_TLAST,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S1_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S1_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S1_AXIS_TUSER,
  input  logic                                S1_AXIS_TVALID,
  output logic                                S1_AXIS_TREADY,
  input  logic                                S1_AXIS_TLAST,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S2_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S2_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S2_AXIS_TUSER,
  input  logic                                S2_AXIS_TVALID,
  output logic                                S2_AXIS_TREADY,
  input  logic                                S2_AXIS_TLAST,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S3_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S3_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S3_AXIS_TUSER,
  input  logic                                S3_AXIS_TVALID,
  output logic                                S3_AXIS_TREADY,
  input  logic                                S3_AXIS_TLAST,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic                                M_AXIS_TLAST,

  output logic [1:0]                          GRANT,
  output logic                                BUSY
);

  localparam int unsigned NumIn  = 4;
  localparam int unsigned Depth  = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned DW     = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned SW     = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned EntryW = DW + SW + UW + 1;
  localparam int unsigned PtrW   = FIFO_DEPTH_BITS;
  localparam int unsigned CntW   = FIFO_DEPTH_BITS + 1;

  // Ready drops one entry early so a beat already in flight always has a slot.
  localparam logic [CntW-1:0] NearlyFullLvl = CntW'(Depth - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  // Entry layout: {last, user, strb, data}
  logic [EntryW-1:0] s_entry [NumIn];
  logic [NumIn-1:0]  s_tvalid;
  logic [NumIn-1:0]  s_tready;

  logic [EntryW-1:0] mem_q    [NumIn][Depth];
  logic [PtrW-1:0]   wr_ptr_q [NumIn];
  logic [PtrW-1:0]   rd_ptr_q [NumIn];
  logic [CntW-1:0]   count_q  [NumIn];
  logic [CntW-1:0]   count_d  [NumIn];
  logic [EntryW-1:0] head     [NumIn];

  logic [NumIn-1:0]  wr_en;
  logic [NumIn-1:0]  rd_en;
  logic [NumIn-1:0]  fifo_empty;

  state_e            state_q;
  logic [1:0]        grant_q;
  logic [1:0]        rr_ptr_q;

  logic              sel_found;
  logic [1:0]        sel_idx;
  logic [1:0]        cand;

  logic [EntryW-1:0] grant_head;
  logic              head_last;
  logic              m_tvalid;
  logic              m_handshake;

  assign s_entry[0] = {S0_AXIS_TLAST, S0_AXIS_TUSER, S0_AXIS_TSTRB, S0_AXIS_TDATA};
  assign s_entry[1] = {S1_AXIS_TLAST, S1_AXIS_TUSER, S1_AXIS_TSTRB, S1_AXIS_TDATA};
  assign s_entry[2] = {S2_AXIS_TLAST, S2_AXIS_TUSER, S2_AXIS_TSTRB, S2_AXIS_TDATA};
  assign s_entry[3] = {S3_AXIS_TLAST, S3_AXIS_TUSER, S3_AXIS_TSTRB, S3_AXIS_TDATA};

  assign s_tvalid = {S3_AXIS_TVALID, S2_AXIS_TVALID, S1_AXIS_TVALID, S0_AXIS_TVALID};

  assign S0_AXIS_TREADY = s_tready[0];
  assign S1_AXIS_TREADY = s_tready[1];
  assign S2_AXIS_TREADY = s_tready[2];
  assign S3_AXIS_TREADY = s_tready[3];

  // FIFO status, write enables and the fallthrough head of every FIFO.
  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      fifo_empty[i] = (count_q[i] == '0);
      s_tready[i]   = (count_q[i] < NearlyFullLvl);
      wr_en[i]      = s_tvalid[i] & s_tready[i];
      head[i]       = mem_q[i][rd_ptr_q[i]];
    end
  end

  // Occupancy next-state; a simultaneous read and write leaves it unchanged.
  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      count_d[i] = count_q[i];
      case ({wr_en[i], rd_en[i]})
        2'b10:   count_d[i] = count_q[i] + CntW'(1);
        2'b01:   count_d[i] = count_q[i] - CntW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // FIFO pointers and occupancy; reset flushes every FIFO, dropping partial packets.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      for (int i = 0; i < NumIn; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NumIn; i++) begin
        if (wr_en[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        end
        if (rd_en[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        end
        count_q[i] <= count_d[i];
      end
    end
  end

  // FIFO storage; needs no reset because occupancy gates every read.
  always_ff @(posedge AXI_ACLK) begin
    for (int i = 0; i < NumIn; i++) begin
      if (wr_en[i]) begin
        mem_q[i][wr_ptr_q[i]] <= s_entry[i];
      end
    end
  end

  // Round-robin pick: first non-empty FIFO starting at rr_ptr_q.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < NumIn; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!sel_found && !fifo_empty[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Master side: drive from the granted FIFO head, zeroed whenever TVALID is low.
  always_comb begin
    grant_head  = head[grant_q];
    head_last   = grant_head[EntryW-1];
    m_tvalid    = (state_q == StSend) && !fifo_empty[grant_q];
    m_handshake = m_tvalid & M_AXIS_TREADY;

    rd_en = '0;
    if (m_handshake) begin
      rd_en[grant_q] = 1'b1;
    end

    M_AXIS_TVALID = m_tvalid;
    M_AXIS_TDATA  = '0;
    M_AXIS_TSTRB  = '0;
    M_AXIS_TUSER  = '0;
    M_AXIS_TLAST  = 1'b0;
    if (m_tvalid) begin
      M_AXIS_TDATA = grant_head[DW-1:0];
      M_AXIS_TSTRB = grant_head[DW +: SW];
      M_AXIS_TUSER = grant_head[DW + SW +: UW];
      M_AXIS_TLAST = head_last;
    end
  end

  // Packet-level arbiter: grant in IDLE, hold it in SEND until TLAST is accepted.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (sel_found) begin
            grant_q <= sel_idx;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (m_handshake && head_last) begin
            rr_ptr_q <= grant_q + 2'd1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign GRANT = grant_q;
  assign BUSY  = (state_q == StSend);

endmodule

// File: tb/tb_nf10_router_input_arbiter.sv
// Bench for nf10_router_input_arbiter: per-input drivers feed directed packets,
// expected output beats are queued in arbitration order and a monitor checks
// every master handshake against that queue.
module tb_nf10_router_input_arbiter;

  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
    int            lat;   // expected input-to-output cycles, 0 = unchecked
    int            gap;   // expected cycles since previous output beat, 0 = unchecked
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  logic [DW-1:0] s_data [4];
  logic [SW-1:0] s_strb [4];
  logic [UW-1:0] s_user [4];
  logic [3:0]    s_valid;
  logic [3:0]    s_last;
  logic [3:0]    s_ready;

  logic [DW-1:0] m_data;
  logic [SW-1:0] m_strb;
  logic [UW-1:0] m_user;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic [1:0]    grant;
  logic          busy;

  beat_t      stim_q [4][$];
  beat_t      exp_q [$];
  int         hs_q [4][$];
  logic [3:0] flush_req;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nf10_router_input_arbiter dut (
    .AXI_ACLK       (clk),
    .AXI_RESETN     (rst_n),
    .S0_AXIS_TDATA  (s_data[0]),
    .S0_AXIS_TSTRB  (s_strb[0]),
    .S0_AXIS_TUSER  (s_user[0]),
    .S0_AXIS_TVALID (s_valid[0]),
    .S0_AXIS_TREADY (s_ready[0]),
    .S0_AXIS_TLAST  (s_last[0]),
    .S1_AXIS_TDATA  (s_data[1]),
    .S1_AXIS_TSTRB  (s_strb[1]),
    .S1_AXIS_TUSER  (s_user[1]),
    .S1_AXIS_TVALID (s_valid[1]),
    .S1_AXIS_TREADY (s_ready[1]),
    .S1_AXIS_TLAST  (s_last[1]),
    .S2_AXIS_TDATA  (s_data[2]),
    .S2_AXIS_TSTRB  (s_strb[2]),
    .S2_AXIS_TUSER  (s_user[2]),
    .S2_AXIS_TVALID (s_valid[2]),
    .S2_AXIS_TREADY (s_ready[2]),
    .S2_AXIS_TLAST  (s_last[2]),
    .S3_AXIS_TDATA  (s_data[3]),
    .S3_AXIS_TSTRB  (s_strb[3]),
    .S3_AXIS_TUSER  (s_user[3]),
    .S3_AXIS_TVALID (s_valid[3]),
    .S3_AXIS_TREADY (s_ready[3]),
    .S3_AXIS_TLAST  (s_last[3]),
    .M_AXIS_TDATA   (m_data),
    .M_AXIS_TSTRB   (m_strb),
    .M_AXIS_TUSER   (m_user),
    .M_AXIS_TVALID  (m_valid),
    .M_AXIS_TREADY  (m_ready),
    .M_AXIS_TLAST   (m_last),
    .GRANT          (grant),
    .BUSY           (busy)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int t, input int src, input int pkt,
                                            input int beat);
    logic [31:0] tag;
    tag = {8'(t), 8'(src), 8'(pkt), 8'(beat)};
    return DW'(tag);
  endfunction

  function automatic logic [UW-1:0] std_user(input int src, input int nbeats);
    logic [63:0] u;
    u = (64'(1) << (16 + 2 * src)) | 64'(nbeats * 32);
    return UW'(u);
  endfunction

  // Queue a packet on input src; the first nexp beats are expected at the output.
  task automatic make_pkt(input int t, input int src, input int pkt, input int nbeats,
                          input int nexp, input int lat0, input int gap0,
                          input logic [UW-1:0] user);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.src  = 2'(src);
      b.data = mk_data(t, src, pkt, k);
      b.strb = (k == nbeats - 1) ? SW'(32'h0000_ffff) : '1;
      b.user = user;
      b.last = (k == nbeats - 1);
      b.lat  = (k == 0) ? lat0 : 0;
      b.gap  = (k == 0) ? gap0 : 1;
      stim_q[src].push_back(b);
      if (k < nexp) exp_q.push_back(b);
    end
  endtask

  task automatic driver(input int i);
    beat_t b;
    logic  fire;
    forever begin
      @(negedge clk);
      fire = s_valid[i] && s_ready[i] && rst_n;
      @(posedge clk);
      #1;
      if (fire) begin
        hs_q[i].push_back(cyc);
        void'(stim_q[i].pop_front());
        s_valid[i] = 1'b0;
      end
      if (flush_req[i]) begin
        stim_q[i].delete();
        hs_q[i].delete();
        s_valid[i] = 1'b0;
      end
      if (!s_valid[i] && stim_q[i].size() > 0) begin
        b          = stim_q[i][0];
        s_data[i]  = b.data;
        s_strb[i]  = b.strb;
        s_user[i]  = b.user;
        s_last[i]  = b.last;
        s_valid[i] = 1'b1;
      end
      if (!s_valid[i]) begin
        s_data[i] = '0;
        s_strb[i] = '0;
        s_user[i] = '0;
        s_last[i] = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    beat_t e;
    int    oc;
    int    last_oc;
    int    hc;
    last_oc = 0;
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        oc = cyc + 1;
        check("beat_expected", DW'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tdata", m_data, e.data);
          check("tstrb", DW'(m_strb), DW'(e.strb));
          check("tuser", DW'(m_user), DW'(e.user));
          check("tlast", DW'(m_last), DW'(e.last));
          check("grant", DW'(grant), DW'(e.src));
          hc = (hs_q[e.src].size() > 0) ? hs_q[e.src].pop_front() : -1000;
          if (e.lat != 0) check("latency", DW'(oc - hc), DW'(e.lat));
          if (e.gap != 0) check("gap", DW'(oc - last_oc), DW'(e.gap));
        end
        last_oc = oc;
      end else if (!m_valid) begin
        check("gated_outputs", DW'(|{m_data, m_strb, m_user, m_last}), 0);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, DW'(exp_q.size()), 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  // Returns at the negedge just before the given beat is accepted downstream.
  task automatic wait_fire(input logic [DW-1:0] data, input string name);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (m_valid && m_ready && m_data == data) found = 1'b1;
    end
    check({name, "_seen"}, DW'(found), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    flush_req = 4'hf;
    repeat (2) @(negedge clk);
    flush_req = 4'h0;
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    s_valid   = '0;
    s_last    = '0;
    flush_req = '0;
    m_ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data[i] = '0;
      s_strb[i] = '0;
      s_user[i] = '0;
    end
    fork
      monitor();
    join_none
    for (int i = 0; i < 4; i++) begin
      automatic int k = i;
      fork
        driver(k);
      join_none
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tvalid", DW'(m_valid), 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_grant", DW'(grant), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tready", DW'(s_ready), 4'hf);
    check("rst_rr_ptr", DW'(dut.rr_ptr_q), 0);

    // 1: single 3-beat packet on S2 with a fixed TUSER
    make_pkt(1, 2, 0, 3, 3, 2, 0, 128'h0000_0000_0000_0000_0000_0400_0000_0004);
    wait_drain("t1");
    check("t1_busy_idle", DW'(busy), 0);

    // 2: 2-beat packets on all four inputs at once
    do_reset();
    for (int s = 0; s < 4; s++) make_pkt(2, s, 0, 2, 2, (s == 0) ? 2 : 0, (s == 0) ? 0 : 2,
                                         std_user(s, 2));
    wait_drain("t2");
    check("t2_rr_ptr", DW'(dut.rr_ptr_q), 0);

    // 3: downstream stall of 5 cycles on beat 2 of a 4-beat S1 packet
    do_reset();
    make_pkt(3, 1, 0, 4, 4, 2, 0, std_user(1, 4));
    exp_q[1].gap = 0;
    wait_fire(mk_data(3, 1, 0, 0), "t3_beat1");
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_hold_tvalid", DW'(m_valid), 1);
      check("t3_hold_tdata", m_data, mk_data(3, 1, 0, 1));
      check("t3_hold_tlast", DW'(m_last), 0);
      if (k >= 1) check("t3_s1_tready", DW'(s_ready[1]), 0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_drain("t3");

    // 4: S0 streams 1-beat packets, S3 joins with one 2-beat packet
    do_reset();
    make_pkt(4, 0, 0, 1, 1, 2, 0, std_user(0, 1));
    make_pkt(4, 3, 0, 2, 2, 0, 2, std_user(3, 2));
    for (int p = 1; p < 4; p++) make_pkt(4, 0, p, 1, 1, 0, 2, std_user(0, 1));
    wait_drain("t4");

    // 5: reset pulsed in the middle of an S1 packet
    do_reset();
    make_pkt(5, 1, 0, 4, 1, 2, 0, std_user(1, 4));
    wait_fire(mk_data(5, 1, 0, 0), "t5_beat1");
    @(posedge clk);
    #1;
    check("t5_valid_before_rst", DW'(m_valid), 1);
    #1;
    rst_n     = 1'b0;
    flush_req = 4'hf;
    #1;
    check("t5_valid_async", DW'(m_valid), 0);
    check("t5_busy_async", DW'(busy), 0);
    repeat (2) @(negedge clk);
    check("t5_fifos_empty", DW'(dut.fifo_empty), 4'hf);
    flush_req = 4'h0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("t5_tready_after", DW'(s_ready), 4'hf);
    make_pkt(5, 0, 1, 2, 2, 2, 0, std_user(0, 2));
    wait_drain("t5");
    check("t5_grant_end", DW'(grant), 0);

    // 6: 1-beat packets alternating between S1 and S2 at full rate
    do_reset();
    for (int p = 0; p < 4; p++) begin
      make_pkt(6, 1, p, 1, 1, (p == 0) ? 2 : 0, (p == 0) ? 0 : 2, std_user(1, 1));
      make_pkt(6, 2, p, 1, 1, 0, 2, std_user(2, 1));
    end
    wait_drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
